yutorina_bus_arbiter: RTL and testbench
=======================================

// Module: yutorina_bus_arbiter
// PURPOSE
//  Shared-bus arbiter and master multiplexer downstream of the per-master bus interface units.
//  Collects the bus_req_ of up to MASTERS masters, issues one registered bus_grnt_ by round-robin,
//  and routes the owner's addr/as_/rw/w_data to the shared slave-side bus.
//  Holds ownership until the owner withdraws its request. Optional watchdog recovers from hung slaves.
// PARAMETERS
//  MASTERS  4    number of masters, 2..4; index 0 wins the first arbitration after reset
//  ADDR_W   30   word-address width (WordAddrBus)
//  DATA_W   32   word-data width (WordDataBus)
//  TIMEOUT  255  cycles without s_rdy_ before forced release (BUS_TIMEOUT_EN only), 1..255
// PORTS
//  clk          in   1                clock; all state updates on rising edge
//  rst          in   1                synchronous reset, active high
//  m_req_       in   MASTERS          per-master bus request, active low
//  m_grnt_      out  MASTERS          per-master grant, active low, registered, at most one low
//  m_addr       in   MASTERS*ADDR_W   packed master addresses, master i at [i*ADDR_W +: ADDR_W]
//  m_as_        in   MASTERS          per-master address strobe, active low
//  m_rw         in   MASTERS          per-master direction, 1=READ 0=WRITE
//  m_w_data     in   MASTERS*DATA_W   packed master write data
//  s_addr       out  ADDR_W           shared-bus address
//  s_as_        out  1                shared-bus address strobe, active low
//  s_rw         out  1                shared-bus direction
//  s_w_data     out  DATA_W           shared-bus write data
//  s_rdy_       in   1                slave ready, active low (used by watchdog only)
//  timeout_err  out  1                one-cycle pulse on forced release; constant 0 without BUS_TIMEOUT_EN
// BEHAVIOUR
//  State: IDLE (no owner) / OWNED (owner index reg, clog2(MASTERS) bits); last_owner reg for rotation.
//  Reset (rst=1 at edge): state=IDLE, all m_grnt_=1, last_owner=MASTERS-1, counter=0, timeout_err=0.
//  Selection: first i with m_req_[i]=0 scanning last_owner+1, +2, ... mod MASTERS (wraps past MASTERS-1 to 0).
//  IDLE: any request low at edge N -> OWNED, winner's m_grnt_ low from N+1. No request -> stay IDLE.
//  OWNED, owner m_req_ low -> keep grant; other requests ignored (no preemption).
//  OWNED, owner m_req_ high at edge N -> last_owner=owner; if another request pending, grant next
//    winner from N+1 (zero-gap handoff, the old grant drops in the same cycle); else IDLE from N+1.
//  The releasing master is never re-granted in the handoff cycle even if it re-requests; it is
//    eligible again from the next arbitration.
//  Mux (combinational from owner reg): s_addr/s_as_/s_rw/s_w_data = owner's inputs.
//  IDLE: s_as_=1, s_rw=1 (READ), s_addr=0, s_w_data=0.
//  Request from a master with MASTERS <= index: impossible by width; unused bits do not exist.
//  Reset mid-ownership: grant dropped next edge, outputs to IDLE values, rotation restarts at 0.
// CONFIGURATION
//  BUS_TIMEOUT_EN defined: 8-bit counter clears on each grant and whenever s_rdy_=0; increments
//    each OWNED cycle with s_rdy_=1. On reaching TIMEOUT: grant forcibly released (same handoff rules),
//    timeout_err=1 for that one cycle; the offending master is masked from arbitration until it
//    drives m_req_ high for at least one cycle.
//  BUS_TIMEOUT_EN undefined: no counter or mask logic; timeout_err tied 0; ownership unbounded.
// TESTING
//  T1 reset: rst=1 two cycles with m_req_=4'b0000 -> m_grnt_=4'b1111, s_as_=1, s_rw=1, timeout_err=0.
//  T2 latency: m_req_=4'b1101 from cycle 3 -> m_grnt_=4'b1101 at cycle 4; m1_addr=30'h1234 appears on s_addr.
//  T3 round-robin: m_req_=4'b0000, each owner holds 2 cycles then releases 1 cycle -> grant order 0,1,2,3,0.
//  T4 handoff: m0 owns, m2 waiting; m0 req_ high at edge N -> m_grnt_=4'b1011 at N+1, no idle cycle.
//  T5 reset mid-ownership: m3 owns, write in flight, rst=1 -> m_grnt_=4'b1111 next edge; next grant to m0.
//  T6 timeout (BUS_TIMEOUT_EN, TIMEOUT=8): m1 owns, s_rdy_=1 held -> after 8 OWNED cycles forced release,
//     timeout_err pulses 1 cycle, m1 ungranted while its m_req_ stays low, m2 granted if requesting.

Source files
------------

// File: rtl/yutorina_bus_arbiter.sv
// yutorina_bus_arbiter: round-robin shared-bus arbiter and master mux, registered active-low grants.
// Define BUS_TIMEOUT_EN to add the hung-slave watchdog with forced release and requester masking.
module yutorina_bus_arbiter #(
  parameter int MASTERS = 4,
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [MASTERS-1:0]          m_req_,
  output logic [MASTERS-1:0]          m_grnt_,
  input  logic [MASTERS*ADDR_W-1:0]   m_addr,
  input  logic [MASTERS-1:0]          m_as_,
  input  logic [MASTERS-1:0]          m_rw,
  input  logic [MASTERS*DATA_W-1:0]   m_w_data,
  output logic [ADDR_W-1:0]           s_addr,
  output logic                        s_as_,
  output logic                        s_rw,
  output logic [DATA_W-1:0]           s_w_data,
  input  logic                        s_rdy_,
  output logic                        timeout_err
);
  localparam int IW = $clog2(MASTERS);
  typedef enum logic {IDLE, OWNED} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] owner_q, owner_d, last_q, last_d, base, win;
  logic [MASTERS-1:0] cand, mask, grnt_d;
  logic found, hold, release_w, tout, owned;
  int idx;
  assign owned = state_q == OWNED;
  assign hold = owned && !m_req_[owner_q] && !tout;
  assign release_w = owned && !hold;
  assign base = owned ? owner_q : last_q;
  // the current owner is excluded so a releasing master never wins its own handoff
  assign cand = ~m_req_ & ~mask & (owned ? ~(MASTERS'(1) << owner_q) : '1);
  always_comb begin
    found = 1'b0;
    win = '0;
    idx = 0;
    for (int k = 1; k <= MASTERS; k++) begin
      idx = (int'(base) + k) % MASTERS;
      if (!found && cand[idx]) begin
        win = IW'(idx);
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_d = (hold || found) ? OWNED : IDLE;
    owner_d = hold ? owner_q : (found ? win : owner_q);
    last_d = release_w ? owner_q : last_q;
    grnt_d = (state_d == OWNED) ? ~(MASTERS'(1) << owner_d) : '1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q <= IW'(MASTERS - 1);
      m_grnt_ <= '1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q <= last_d;
      m_grnt_ <= grnt_d;
    end
  end
`ifdef BUS_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic [MASTERS-1:0] mask_q, mask_d;
  logic err_q;
  assign tout = owned && s_rdy_ && (cnt_q == 8'(TIMEOUT - 1));
  assign cnt_d = (!owned || !s_rdy_ || (!hold && state_d == OWNED)) ? '0 : cnt_q + 8'd1;
  // a timed-out master stays masked until it lets go of its request for a cycle
  assign mask_d = (mask_q | (tout ? (MASTERS'(1) << owner_q) : '0)) & ~m_req_;
  assign mask = mask_q;
  assign timeout_err = err_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      mask_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      mask_q <= mask_d;
      err_q <= tout;
    end
  end
`else
  assign tout = 1'b0;
  assign mask = '0;
  assign timeout_err = 1'b0;
`endif
  assign s_addr = owned ? m_addr[owner_q*ADDR_W +: ADDR_W] : '0;
  assign s_as_ = owned ? m_as_[owner_q] : 1'b1;
  assign s_rw = owned ? m_rw[owner_q] : 1'b1;
  assign s_w_data = owned ? m_w_data[owner_q*DATA_W +: DATA_W] : '0;
endmodule

// File: tb/tb_yutorina_bus_arbiter.sv
// tb_yutorina_bus_arbiter: directed vectors for the 4-master arbiter with TIMEOUT=8.
module tb_yutorina_bus_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] m_req_, m_grnt_, m_as_, m_rw;
  logic [119:0] m_addr;
  logic [127:0] m_w_data;
  logic [29:0] s_addr;
  logic s_as_, s_rw, s_rdy_, timeout_err;
  logic [31:0] s_w_data;
  logic [3:0] exp_g;
  int vectors = 0;
  int errs = 0;

  yutorina_bus_arbiter #(.MASTERS(4), .ADDR_W(30), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .m_req_(m_req_), .m_grnt_(m_grnt_), .m_addr(m_addr),
    .m_as_(m_as_), .m_rw(m_rw), .m_w_data(m_w_data), .s_addr(s_addr), .s_as_(s_as_),
    .s_rw(s_rw), .s_w_data(s_w_data), .s_rdy_(s_rdy_), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    m_req_ = 4'b0000;
    m_as_ = 4'b1111;
    m_rw = 4'b1111;
    s_rdy_ = 1'b1;
    m_addr = {30'h3333, 30'h2222, 30'h1234, 30'h0100};
    m_w_data = {32'hDA7A0003, 32'hDA7A0002, 32'hDA7A0001, 32'hDA7A0000};
    // T1 reset
    step();
    step();
    chk("t1_grnt", m_grnt_, 4'b1111);
    chk("t1_as", s_as_, 1'b1);
    chk("t1_rw", s_rw, 1'b1);
    chk("t1_addr", s_addr, 30'h0);
    chk("t1_err", timeout_err, 1'b0);
    // T2 latency and mux
    rst = 1'b0;
    m_req_ = 4'b1111;
    step();
    chk("t2_idle", m_grnt_, 4'b1111);
    m_req_ = 4'b1101;
    step();
    chk("t2_grnt", m_grnt_, 4'b1101);
    m_as_ = 4'b1101;
    m_rw = 4'b1101;
    #1;
    chk("t2_addr", s_addr, 30'h1234);
    chk("t2_as", s_as_, 1'b0);
    chk("t2_rw", s_rw, 1'b0);
    chk("t2_wdata", s_w_data, 32'hDA7A0001);
    m_req_ = 4'b1111;
    m_as_ = 4'b1111;
    m_rw = 4'b1111;
    step();
    chk("t2_release", m_grnt_, 4'b1111);
    chk("t2_idle_addr", s_addr, 30'h0);
    chk("t2_idle_wdata", s_w_data, 32'h0);
    // T3 round-robin from a fresh reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_req_ = 4'b0000;
    step();
    chk("t3_first", m_grnt_, 4'b1110);
    for (int i = 0; i < 4; i++) begin
      step();
      exp_g = ~(4'b0001 << i);
      chk($sformatf("t3_hold%0d", i), m_grnt_, exp_g);
      m_req_ = 4'b0001 << i;
      step();
      exp_g = ~(4'b0001 << ((i + 1) % 4));
      chk($sformatf("t3_next%0d", i), m_grnt_, exp_g);
      m_req_ = 4'b0000;
    end
    m_req_ = 4'b1111;
    step();
    chk("t3_idle", m_grnt_, 4'b1111);
    // T4 zero-gap handoff, no preemption; last owner is m0 so idle scan reaches m0 last
    m_req_ = 4'b1110;
    step();
    chk("t4_m0", m_grnt_, 4'b1110);
    m_req_ = 4'b1010;
    step();
    chk("t4_nopreempt", m_grnt_, 4'b1110);
    m_req_ = 4'b1011;
    step();
    chk("t4_handoff", m_grnt_, 4'b1011);
    m_req_ = 4'b1111;
    step();
    chk("t4_idle", m_grnt_, 4'b1111);
    // T5 reset mid-ownership; last owner m2 so m3 wins
    m_req_ = 4'b0111;
    step();
    chk("t5_m3", m_grnt_, 4'b0111);
    m_as_ = 4'b0111;
    m_rw = 4'b0111;
    #1;
    chk("t5_wdata", s_w_data, 32'hDA7A0003);
    chk("t5_rw", s_rw, 1'b0);
    rst = 1'b1;
    step();
    chk("t5_rst_grnt", m_grnt_, 4'b1111);
    chk("t5_rst_as", s_as_, 1'b1);
    chk("t5_rst_rw", s_rw, 1'b1);
    chk("t5_rst_wdata", s_w_data, 32'h0);
    rst = 1'b0;
    m_req_ = 4'b0000;
    m_as_ = 4'b1111;
    m_rw = 4'b1111;
    step();
    chk("t5_restart", m_grnt_, 4'b1110);
    m_req_ = 4'b1111;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    // T6 watchdog: m1 owns (m0 idle, last=3), m2 waits
    m_req_ = 4'b1001;
    step();
    chk("t6_m1", m_grnt_, 4'b1101);
`ifdef BUS_TIMEOUT_EN
    for (int i = 0; i < 7; i++) step();
    chk("t6_still", m_grnt_, 4'b1101);
    chk("t6_noerr", timeout_err, 1'b0);
    step();
    chk("t6_forced", m_grnt_, 4'b1011);
    chk("t6_err", timeout_err, 1'b1);
    step();
    chk("t6_pulse", timeout_err, 1'b0);
    chk("t6_m2", m_grnt_, 4'b1011);
    m_req_ = 4'b1101;
    step();
    chk("t6_masked", m_grnt_, 4'b1111);
    step();
    chk("t6_masked2", m_grnt_, 4'b1111);
    m_req_ = 4'b1111;
    step();
    m_req_ = 4'b1101;
    step();
    chk("t6_unmasked", m_grnt_, 4'b1101);
    s_rdy_ = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("t6_rdy_hold", m_grnt_, 4'b1101);
    chk("t6_rdy_noerr", timeout_err, 1'b0);
`else
    for (int i = 0; i < 12; i++) step();
    chk("t6_unbounded", m_grnt_, 4'b1101);
    chk("t6_err_tied", timeout_err, 1'b0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
